// File: rtl/shooter_sprite_renderer_pkg.sv
// Purpose : shared types and constants for the sprite renderer slice.
// Latency : n/a (declarations only).
// Backpressure: n/a; holds the FSM encoding, sprite size defaults and reset position.
package shooter_sprite_renderer_pkg;

    localparam int SPRITE_W_DEF = 16;
    localparam int SPRITE_H_DEF = 16;
    localparam int COORD_W_DEF  = 10;

    // Power-up sprite position (bottom-centre of a 640x480 screen).
    localparam int RESET_POS_X = 312;
    localparam int RESET_POS_Y = 440;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARMED = 3'd3,
        ST_DRAW  = 3'd4
    } state_t;

endpackage

// File: rtl/shooter_sprite_renderer_if.sv
// Purpose : video timing, position update and sprite ROM signals of the renderer.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are pixel-clock strobes or levels.
// Ports   : master = timing source / ROM side, slave = renderer.
interface shooter_sprite_renderer_if
    import shooter_sprite_renderer_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int SPRITE_W = SPRITE_W_DEF
);
    logic [COORD_W-1:0]  pix_x;
    logic                video_active;
    logic                line_start;
    logic [COORD_W-1:0]  line_y;
    logic                frame_start;
    logic [COORD_W-1:0]  pos_x;
    logic [COORD_W-1:0]  pos_y;
    logic                pos_load;
    logic [3:0]          rom_row_index;
    logic [SPRITE_W-1:0] rom_row_data;
    logic                pixel_on;

    modport master (
        output pix_x, video_active, line_start, line_y, frame_start,
        output pos_x, pos_y, pos_load, rom_row_data,
        input  rom_row_index, pixel_on
    );

    modport slave (
        input  pix_x, video_active, line_start, line_y, frame_start,
        input  pos_x, pos_y, pos_load, rom_row_data,
        output rom_row_index, pixel_on
    );
endinterface

// File: rtl/sprite_pos_shadow.sv
// Purpose : pending/active sprite position pair; pending follows pos_load, active follows frame_start.
// Latency : 1 cycle from pos_load/frame_start to register update.
// Backpressure: none; pos_load and frame_start together write the new position to both registers.
// Ports   : clk, reset, pos_x/pos_y/pos_load, frame_start in; active_x/active_y out.
module sprite_pos_shadow
    import shooter_sprite_renderer_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               pos_load,
    input  logic               frame_start,
    output logic [COORD_W-1:0] active_x,
    output logic [COORD_W-1:0] active_y
);
    logic [COORD_W-1:0] pending_x;
    logic [COORD_W-1:0] pending_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_x <= COORD_W'(RESET_POS_X);
            pending_y <= COORD_W'(RESET_POS_Y);
            active_x  <= COORD_W'(RESET_POS_X);
            active_y  <= COORD_W'(RESET_POS_Y);
        end else begin
            if (pos_load) begin
                pending_x <= pos_x;
                pending_y <= pos_y;
            end
            // A coincident load bypasses the pending stage so it is not lost for a frame.
            if (frame_start) begin
                active_x <= pos_load ? pos_x : pending_x;
                active_y <= pos_load ? pos_y : pending_y;
            end
        end
    end
endmodule

// File: rtl/shooter_sprite_renderer.sv
// Purpose : per-line sprite renderer: fetches one ROM row in hblank and shifts it out at the sprite column.
// Latency : pixel_on is registered, 1 cycle after the pix_x it belongs to.
// Backpressure: none; a new line_start aborts any line in progress, video_active low clips the draw.
// Ports   : clk, reset (sync, active-high) plus the slave side of shooter_sprite_renderer_if.
module shooter_sprite_renderer
    import shooter_sprite_renderer_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    shooter_sprite_renderer_if.slave bus
);
    localparam int CNT_W = $clog2(SPRITE_W) + 1;

    logic [COORD_W-1:0]  active_x;
    logic [COORD_W-1:0]  active_y;

    state_t              state, state_nxt;
    logic [COORD_W-1:0]  row;
    logic [COORD_W-1:0]  draw_x, draw_x_nxt;
    logic [3:0]          rom_idx_nxt;
    logic [SPRITE_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                pix_nxt;

    sprite_pos_shadow #(.COORD_W(COORD_W)) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .pos_x       (bus.pos_x),
        .pos_y       (bus.pos_y),
        .pos_load    (bus.pos_load),
        .frame_start (bus.frame_start),
        .active_x    (active_x),
        .active_y    (active_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            draw_x            <= '0;
            shreg             <= '0;
            cnt               <= '0;
            bus.rom_row_index <= '0;
            bus.pixel_on      <= 1'b0;
        end else begin
            state             <= state_nxt;
            draw_x            <= draw_x_nxt;
            shreg             <= shreg_nxt;
            cnt               <= cnt_nxt;
            bus.rom_row_index <= rom_idx_nxt;
            bus.pixel_on      <= pix_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        draw_x_nxt  = draw_x;
        rom_idx_nxt = bus.rom_row_index;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        pix_nxt     = 1'b0;
        // Modular subtraction: lines above the sprite wrap to a large row and fall out of range.
        row         = bus.line_y - active_y;

        if (bus.line_start) begin
            // Evaluated identically from every state, so a late line_start simply restarts the line.
            if (row < COORD_W'(SPRITE_H)) begin
                state_nxt   = ST_FETCH;
                rom_idx_nxt = row[3:0];
                // Column is frozen here so a frame_start later in the line cannot move it.
                draw_x_nxt  = active_x;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            unique case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_FETCH: state_nxt = ST_LOAD;
                ST_LOAD: begin
                    shreg_nxt = bus.rom_row_data;
                    cnt_nxt   = '0;
                    state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (bus.video_active && bus.pix_x == draw_x) begin
                        pix_nxt   = shreg[SPRITE_W-1];
                        shreg_nxt = shreg << 1;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (!bus.video_active) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        pix_nxt   = shreg[SPRITE_W-1];
                        shreg_nxt = shreg << 1;
                        cnt_nxt   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(SPRITE_W - 1)) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shooter_sprite_renderer.sv
// Purpose : directed self-checking bench for shooter_sprite_renderer with a small ROM model.
// Latency : checks pixel_on one cycle after each pix_x.
// Backpressure: n/a; all loops are fixed-length.
module tb_shooter_sprite_renderer;
    import shooter_sprite_renderer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    shooter_sprite_renderer_if #(.COORD_W(10), .SPRITE_W(16)) bus ();

    shooter_sprite_renderer #(.SPRITE_W(16), .SPRITE_H(16), .COORD_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sprite ROM model, MSB = leftmost pixel.
    function automatic logic [15:0] rom_row(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_row = 16'h0180;
            4'd1:    rom_row = 16'hC003;
            4'd7:    rom_row = 16'hFFFF;
            default: rom_row = 16'h8001;
        endcase
    endfunction

    assign bus.rom_row_data = rom_row(bus.rom_row_index);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input int ly, output int idx, output int st);
        bus.video_active = 1'b0;
        bus.pix_x        = 10'd700;
        bus.line_y       = 10'(ly);
        bus.line_start   = 1'b1;
        tick();
        bus.line_start   = 1'b0;
        idx = int'(bus.rom_row_index);
        st  = int'(dut.state);
        tick();
        tick();
        tick();
    endtask

    // Sweeps visible columns x0..x1; counts lit pixels and records first/last lit column.
    task automatic sweep(input int x0, input int x1, output int cnt, output int first, output int last);
        cnt   = 0;
        first = -1;
        last  = -1;
        for (int x = x0; x <= x1; x++) begin
            bus.pix_x        = 10'(x);
            bus.video_active = 1'b1;
            tick();
            if (bus.pixel_on) begin
                cnt++;
                if (first < 0) first = x;
                last = x;
            end
        end
    endtask

    task automatic run_line(input string tag, input int ly, output int idx, output int st,
                            output int cnt, output int first, output int last);
        pulse_line(ly, idx, st);
        sweep(0, 639, cnt, first, last);
        bus.video_active = 1'b0;
        bus.pix_x        = 10'd640;
        tick();
        check_val({tag, "_tail_off"}, int'(bus.pixel_on), 0);
        tick();
        tick();
    endtask

    int idx, st, cnt, first, last;

    initial begin
        checks   = 0;
        failures = 0;
        reset             = 1'b1;
        bus.pix_x         = '0;
        bus.video_active  = 1'b0;
        bus.line_start    = 1'b0;
        bus.line_y        = '0;
        bus.frame_start   = 1'b0;
        bus.pos_x         = '0;
        bus.pos_y         = '0;
        bus.pos_load      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_val("rst_pixel_on", int'(bus.pixel_on), 0);
        check_val("rst_rom_idx", int'(bus.rom_row_index), 0);
        check_val("rst_state", int'(dut.state), int'(ST_IDLE));
        check_val("rst_active_x", int'(dut.u_shadow.active_x), 312);
        check_val("rst_active_y", int'(dut.u_shadow.active_y), 440);

        // Row 0 at (312,440): 0x0180 lights columns 319 and 320
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        run_line("row0", 440, idx, st, cnt, first, last);
        check_val("row0_idx", idx, 0);
        check_val("row0_cnt", cnt, 2);
        check_val("row0_first", first, 319);
        check_val("row0_last", last, 320);

        // Row 7: solid row, 312..327
        run_line("row7", 447, idx, st, cnt, first, last);
        check_val("row7_idx", idx, 7);
        check_val("row7_cnt", cnt, 16);
        check_val("row7_first", first, 312);
        check_val("row7_last", last, 327);

        // Out-of-range lines just above and just below the sprite
        run_line("y439", 439, idx, st, cnt, first, last);
        check_val("y439_state", st, int'(ST_IDLE));
        check_val("y439_cnt", cnt, 0);
        run_line("y456", 456, idx, st, cnt, first, last);
        check_val("y456_state", st, int'(ST_IDLE));
        check_val("y456_cnt", cnt, 0);

        // line_start mid-draw aborts and fetches the new row (row 1 = 0xC003)
        pulse_line(447, idx, st);
        sweep(0, 315, cnt, first, last);
        check_val("abort_pre_cnt", cnt, 4);
        check_val("abort_pre_first", first, 312);
        bus.pix_x        = 10'd316;
        bus.video_active = 1'b1;
        bus.line_y       = 10'd441;
        bus.line_start   = 1'b1;
        tick();
        bus.line_start   = 1'b0;
        check_val("abort_px_off", int'(bus.pixel_on), 0);
        check_val("abort_rom_idx", int'(bus.rom_row_index), 1);
        sweep(317, 639, cnt, first, last);
        check_val("abort_rest_cnt", cnt, 0);
        sweep(0, 639, cnt, first, last);
        check_val("abort_new_cnt", cnt, 4);
        check_val("abort_new_first", first, 312);
        check_val("abort_new_last", last, 327);
        bus.video_active = 1'b0;
        tick();

        // Reset mid-draw wins
        pulse_line(447, idx, st);
        sweep(0, 318, cnt, first, last);
        check_val("mid_rst_pre_cnt", cnt, 7);
        reset = 1'b1;
        bus.pix_x = 10'd319;
        tick();
        reset = 1'b0;
        check_val("mid_rst_pixel_on", int'(bus.pixel_on), 0);
        check_val("mid_rst_state", int'(dut.state), int'(ST_IDLE));
        bus.video_active = 1'b0;
        tick();

        // pos_load alone only updates pending; takes effect at frame_start
        bus.pos_x    = 10'd100;
        bus.pos_y    = 10'd200;
        bus.pos_load = 1'b1;
        tick();
        bus.pos_load = 1'b0;
        check_val("pend_active_x", int'(dut.u_shadow.active_x), 312);
        run_line("pend_old", 447, idx, st, cnt, first, last);
        check_val("pend_old_cnt", cnt, 16);
        check_val("pend_old_first", first, 312);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check_val("fs_active_x", int'(dut.u_shadow.active_x), 100);
        check_val("fs_active_y", int'(dut.u_shadow.active_y), 200);
        run_line("new_pos", 200, idx, st, cnt, first, last);
        check_val("new_pos_cnt", cnt, 2);
        check_val("new_pos_first", first, 107);
        check_val("new_pos_last", last, 108);

        // Coincident pos_load + frame_start, right-edge clip at x=630
        bus.pos_x       = 10'd630;
        bus.pos_y       = 10'd100;
        bus.pos_load    = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.pos_load    = 1'b0;
        bus.frame_start = 1'b0;
        check_val("coin_active_x", int'(dut.u_shadow.active_x), 630);
        check_val("coin_pending_x", int'(dut.u_shadow.pending_x), 630);
        run_line("clip", 107, idx, st, cnt, first, last);
        check_val("clip_cnt", cnt, 10);
        check_val("clip_first", first, 630);
        check_val("clip_last", last, 639);
        check_val("clip_state", int'(dut.state), int'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shooter_sprite_renderer.md
SHOOTER_SPRITE_RENDERER -- requirements
Module: shooter_sprite_renderer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 16, sprite width in pixels and ROM row width.
REQ-002 SHALL have parameter SPRITE_H, default 16, sprite height in rows.
REQ-003 SHALL have parameter COORD_W, default 10, screen coordinate width.
REQ-004 SHALL have port clk, input, 1, the single pixel clock.
REQ-005 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port pix_x, input, COORD_W, current pixel column.
REQ-007 SHALL have port video_active, input, 1, high when pix_x is inside the visible area.
REQ-008 SHALL have port line_start, input, 1, one-cycle pulse in horizontal blanking, at least 3 cycles before the next active pixel.
REQ-009 SHALL have port line_y, input, COORD_W, row of the upcoming line; valid while line_start is high.
REQ-010 SHALL have port frame_start, input, 1, one-cycle pulse in vertical blanking.
REQ-011 SHALL have ports pos_x/pos_y, input, COORD_W each, new top-left sprite position.
REQ-012 SHALL have port pos_load, input, 1, captures pos_x/pos_y into the pending registers.
REQ-013 SHALL have port rom_row_index, output, 4, row address to the sprite ROM.
REQ-014 SHALL have port rom_row_data, input, SPRITE_W, combinational ROM row, MSB = leftmost pixel.
REQ-015 SHALL have port pixel_on, output, 1, registered sprite-pixel-lit flag.

Function
REQ-016 SHALL keep active and pending position registers; pos_load writes pending, frame_start copies pending to active.
REQ-017 If pos_load and frame_start coincide, the SHALL rule is that pos_x/pos_y go directly to both active and pending.
REQ-018 SHALL implement FSM states IDLE, FETCH, LOAD, ARMED, DRAW.
REQ-019 IDLE + line_start: row = line_y - active_y (COORD_W modular); if row < SPRITE_H go FETCH, else stay IDLE.
REQ-020 FETCH SHALL drive rom_row_index = row[3:0] and go to LOAD next cycle.
REQ-021 LOAD SHALL capture rom_row_data into a SPRITE_W shift register, clear the pixel counter and go to ARMED.
REQ-022 ARMED + video_active + pix_x == active_x SHALL go DRAW, emitting the shift-register MSB this cycle.
REQ-023 DRAW SHALL shift left once per cycle; after SPRITE_W pixels emitted return to IDLE.
REQ-024 pixel_on SHALL be registered: pixel_on at t+1 = emitted bit for pix_x at t; 0 in every other state.
REQ-025 video_active low during DRAW (right-edge clipping) SHALL abort to IDLE with pixel_on 0; no horizontal wrap.
REQ-026 line_start in any state other than IDLE SHALL abort and be re-evaluated as in IDLE in the same cycle.
REQ-027 frame_start SHALL NOT disturb a line in progress; the new position affects the next line_start only.
REQ-028 Rows with line_y < active_y (modular underflow producing a large row) SHALL be out of range.

Reset
REQ-029 On reset: state IDLE, pixel_on 0, rom_row_index 0, shift register 0, counter 0.
REQ-030 On reset: active and pending position = (312, 440).
REQ-031 Reset SHALL take priority over every other input, including mid-DRAW.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding, SPRITE_W/SPRITE_H defaults and the reset position constants.
REQ-033 Position shadow logic SHALL be the single sub-module sprite_pos_shadow; the ROM is instantiated outside this block.

Verification
REQ-034 Reset, frame_start, line_start with line_y=440, then pix_x sweep -> pixel_on at cycles after pix_x 319,320 only (row 0 = 0x0180).
REQ-035 line_y=447 at pos (312,440) -> rom_row_index=7; 16 consecutive pixel_on=1 for pix_x 312..327.
REQ-036 pos_load (100,200) mid-frame -> no change until frame_start; next line_y=200 draws at pix_x 100.
REQ-037 pos_x=630, line_y at row 7 -> pixel_on for pix_x 630..639 only, then IDLE.
REQ-038 line_start during DRAW -> draw aborts, new row fetched, pixel_on 0 until new match.
REQ-039 line_y=439 and line_y=456 with pos_y=440 -> FSM stays IDLE, pixel_on never asserted.
